pipeline_hazard_ctrl: RTL and testbench

Sequencing controller for the 5-stage pipelined datapath. It drives the PC_write and IF_ID_Write hooks that are currently tied high, and generates the stage flush and freeze controls. It handles load-use stalls, taken-branch flushes resolved in MEM, and variable-latency data-memory waits. It also keeps saturating stall and flush counters and a sticky memory-timeout error.

---
 rtl/pipeline_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Sequencing controller for the 5-stage pipeline. It stalls on load-use
// hazards, flushes the front of the pipe on taken branches resolved in MEM,
// and freezes the pipe while the data memory is busy. It also keeps
// saturating stall/flush counters and a sticky memory-timeout flag.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   ID_Rs, ID_Rt, EX_Rt           register fields for load-use detection
//   EX_MemRead                    load in EX
//   MEM_PCSrc                     taken branch resolved in MEM
//   MEM_MemRead, MEM_MemWrite     memory access in MEM
//   dmem_ready                    data memory completes this cycle
//   PC_write, IF_ID_Write         front-end load enables
//   IF_ID_Flush, ID_EX_Flush,
//   EX_MEM_Flush                  stage flush controls
//   pipe_hold                     freeze ID/EX, EX/MEM, MEM/WB
//   stall_count, flush_count      saturating performance counters
//   mem_err                       sticky MEM_WAIT timeout flag
//   state                         0=RUN, 1=LOAD_STALL, 2=MEM_WAIT
module pipeline_hazard_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic [4:0]       EX_Rt,
    input  logic             EX_MemRead,
    input  logic             MEM_PCSrc,
    input  logic             MEM_MemRead,
    input  logic             MEM_MemWrite,
    input  logic             dmem_ready,
    output logic             PC_write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_err,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [3:0]       REM_INIT    = 4'(STALL_CYCLES - 1);
    localparam logic [15:0]      TIMEOUT_VAL = 16'(MEM_TIMEOUT);

    state_t            state_reg, state_next;
    logic [3:0]        rem_reg, rem_next;
    logic [15:0]       wait_cnt_reg, wait_cnt_next;
    logic              mem_err_reg, mem_err_next;
    logic [CNT_W-1:0]  stall_count_reg, flush_count_reg;

    logic memacc, mem_miss, lu_haz;
    logic do_hold, do_flush, do_stall;

    assign memacc   = MEM_MemRead | MEM_MemWrite;
    assign mem_miss = memacc & ~dmem_ready;
    // EX_Rt == 0 is excluded: $zero is never a real producer.
    assign lu_haz   = EX_MemRead && (EX_Rt != 5'd0) &&
                      ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));

    // Decide the action for this cycle (memory wait > branch flush > load-use)
    // and the next-state values.
    always_comb begin
        do_hold       = 1'b0;
        do_flush      = 1'b0;
        do_stall      = 1'b0;
        state_next    = state_reg;
        rem_next      = rem_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_err_next  = mem_err_reg;
        case (state_reg)
            RUN: begin
                if (mem_miss) begin
                    do_hold       = 1'b1;
                    state_next    = MEM_WAIT;
                    wait_cnt_next = 16'd1;
                end else if (MEM_PCSrc) begin
                    do_flush = 1'b1;
                end else if (lu_haz) begin
                    do_stall = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_next = LOAD_STALL;
                        rem_next   = REM_INIT;
                    end
                end
            end
            LOAD_STALL: begin
                if (mem_miss) begin
                    // rem is kept so the stall resumes after the wait
                    do_hold       = 1'b1;
                    state_next    = MEM_WAIT;
                    wait_cnt_next = 16'd1;
                end else if (MEM_PCSrc) begin
                    do_flush   = 1'b1;
                    state_next = RUN;
                    rem_next   = 4'd0;
                end else begin
                    do_stall = 1'b1;
                    if (rem_reg <= 4'd1) begin
                        state_next = RUN;
                        rem_next   = 4'd0;
                    end else begin
                        rem_next = rem_reg - 4'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_next    = (rem_reg != 4'd0) ? LOAD_STALL : RUN;
                    wait_cnt_next = 16'd0;
                end else if (wait_cnt_reg >= TIMEOUT_VAL) begin
                    // Give up: release the pipe as if the access completed.
                    mem_err_next  = 1'b1;
                    state_next    = RUN;
                    rem_next      = 4'd0;
                    wait_cnt_next = 16'd0;
                end else begin
                    do_hold       = 1'b1;
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
            end
            default: begin
                state_next    = RUN;
                rem_next      = 4'd0;
                wait_cnt_next = 16'd0;
            end
        endcase
    end

    // Mealy outputs; everything is disabled while reset is asserted.
    assign PC_write     = ~rst & ~(do_hold | do_stall);
    assign IF_ID_Write  = ~rst & ~(do_hold | do_stall);
    assign IF_ID_Flush  = ~rst & do_flush;
    assign ID_EX_Flush  = ~rst & (do_flush | do_stall);
    assign EX_MEM_Flush = ~rst & do_flush;
    assign pipe_hold    = ~rst & do_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= RUN;
            rem_reg         <= 4'd0;
            wait_cnt_reg    <= 16'd0;
            mem_err_reg     <= 1'b0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rem_reg      <= rem_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
            if (!PC_write && stall_count_reg != CNT_MAX)
                stall_count_reg <= stall_count_reg + 1'b1;
            if (do_flush && flush_count_reg != CNT_MAX)
                flush_count_reg <= flush_count_reg + 1'b1;
        end
    end

    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;
    assign mem_err     = mem_err_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances share the
// stimulus: u1 (STALL_CYCLES=1, MEM_TIMEOUT=4, CNT_W=4) and
// u3 (STALL_CYCLES=3, MEM_TIMEOUT=255, CNT_W=16).
module tb_pipeline_hazard_ctrl;

    // control vector: {PC_write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, pipe_hold}
    localparam logic [5:0] C_DEF   = 6'b110000;
    localparam logic [5:0] C_STALL = 6'b000100;
    localparam logic [5:0] C_FLUSH = 6'b111110;
    localparam logic [5:0] C_HOLD  = 6'b000001;
    localparam logic [5:0] C_RST   = 6'b000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic ex_mr = 1'b0, pcsrc = 1'b0, mmr = 1'b0, mmw = 1'b0, rdy = 1'b1;

    logic pcw1, ifw1, iff1, idf1, exf1, hold1, err1;
    logic [3:0] sc1, fc1;
    logic [1:0] st1;
    logic pcw3, ifw3, iff3, idf3, exf3, hold3, err3;
    logic [15:0] sc3, fc3;
    logic [1:0] st3;
    logic [5:0] c1, c3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.STALL_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .EX_Rt(ex_rt),
        .EX_MemRead(ex_mr), .MEM_PCSrc(pcsrc), .MEM_MemRead(mmr),
        .MEM_MemWrite(mmw), .dmem_ready(rdy), .PC_write(pcw1),
        .IF_ID_Write(ifw1), .IF_ID_Flush(iff1), .ID_EX_Flush(idf1),
        .EX_MEM_Flush(exf1), .pipe_hold(hold1), .stall_count(sc1),
        .flush_count(fc1), .mem_err(err1), .state(st1)
    );

    pipeline_hazard_ctrl #(.STALL_CYCLES(3), .MEM_TIMEOUT(255), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .EX_Rt(ex_rt),
        .EX_MemRead(ex_mr), .MEM_PCSrc(pcsrc), .MEM_MemRead(mmr),
        .MEM_MemWrite(mmw), .dmem_ready(rdy), .PC_write(pcw3),
        .IF_ID_Write(ifw3), .IF_ID_Flush(iff3), .ID_EX_Flush(idf3),
        .EX_MEM_Flush(exf3), .pipe_hold(hold3), .stall_count(sc3),
        .flush_count(fc3), .mem_err(err3), .state(st3)
    );

    assign c1 = {pcw1, ifw1, iff1, idf1, exf1, hold1};
    assign c3 = {pcw3, ifw3, iff3, idf3, exf3, hold3};

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] exrt;
        logic       exmr;
        logic       br;
        logic       mr;
        logic       mw;
        logic       rd;
        logic [5:0] ctrl;
        logic [1:0] st;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] er,
                         input logic emr, input logic br, input logic mr,
                         input logic mw, input logic rd);
        id_rs = rs; id_rt = rt; ex_rt = er; ex_mr = emr;
        pcsrc = br; mmr = mr; mmw = mw; rdy = rd;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Check one cycle's control outputs and state, then advance past the edge.
    task automatic cyc(input string nm, input int sel, input logic [5:0] ce, input logic [1:0] se);
        @(negedge clk);
        if (sel == 1) begin
            chk({nm, ".ctrl"}, 32'(c1), 32'(ce));
            chk({nm, ".state"}, 32'(st1), 32'(se));
        end else begin
            chk({nm, ".ctrl"}, 32'(c3), 32'(ce));
            chk({nm, ".state"}, 32'(st3), 32'(se));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rs    rt    exrt  exmr br    mr    mw    rd    ctrl     st
        tbl[0]  = '{5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_STALL, 2'd0};
        tbl[1]  = '{5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_DEF,   2'd0};
        tbl[2]  = '{5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_STALL, 2'd0};
        tbl[3]  = '{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_DEF,   2'd0};
        tbl[4]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C_FLUSH, 2'd0};
        tbl[5]  = '{5'd2, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, C_FLUSH, 2'd0};
        tbl[6]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_HOLD,  2'd0};
        tbl[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_HOLD,  2'd2};
        tbl[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, C_HOLD,  2'd2};
        tbl[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, C_DEF,   2'd2};
        tbl[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF,   2'd0};
        tbl[11] = '{5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, C_STALL, 2'd0};
        tbl[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_HOLD,  2'd0};
        tbl[13] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_DEF,   2'd2};

        // Reset state while rst is held
        idle();
        @(negedge clk);
        chk("rst.ctrl", 32'(c1), 32'(C_RST));
        chk("rst.state", 32'(st1), 32'd0);
        chk("rst.stall_count", 32'(sc1), 32'd0);
        chk("rst.flush_count", 32'(fc1), 32'd0);
        chk("rst.mem_err", 32'(err1), 32'd0);
        do_reset();

        // Table-driven single-cycle vectors on u1
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rs, tbl[i].rt, tbl[i].exrt, tbl[i].exmr,
                  tbl[i].br, tbl[i].mr, tbl[i].mw, tbl[i].rd);
            cyc($sformatf("vec%0d", i), 1, tbl[i].ctrl, tbl[i].st);
        end
        chk("vec.stall_count", 32'(sc1), 32'd7);
        chk("vec.flush_count", 32'(fc1), 32'd2);

        // 3-cycle memory wait on u1
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("mw.c1", 1, C_HOLD, 2'd0);
        cyc("mw.c2", 1, C_HOLD, 2'd2);
        cyc("mw.c3", 1, C_HOLD, 2'd2);
        rdy = 1'b1;
        cyc("mw.rel", 1, C_DEF, 2'd2);
        idle();
        chk("mw.stall_count", 32'(sc1), 32'd3);

        // Branch together with load-use on u3: flush wins
        do_reset();
        drive(5'd2, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("brlu.c1", 3, C_FLUSH, 2'd0);
        idle();
        cyc("brlu.c2", 3, C_DEF, 2'd0);
        chk("brlu.stall_count", 32'(sc3), 32'd0);
        chk("brlu.flush_count", 32'(fc3), 32'd1);

        // STALL_CYCLES=3 with a memory wait preempting the stall
        do_reset();
        drive(5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lsmw.c1", 3, C_STALL, 2'd0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("lsmw.c2", 3, C_HOLD, 2'd1);
        cyc("lsmw.c3", 3, C_HOLD, 2'd2);
        cyc("lsmw.c4", 3, C_HOLD, 2'd2);
        rdy = 1'b1;
        cyc("lsmw.c5", 3, C_DEF, 2'd2);
        idle();
        cyc("lsmw.c6", 3, C_STALL, 2'd1);
        cyc("lsmw.c7", 3, C_STALL, 2'd1);
        cyc("lsmw.c8", 3, C_DEF, 2'd0);
        chk("lsmw.stall_count", 32'(sc3), 32'd6);

        // Branch preempting LOAD_STALL
        do_reset();
        drive(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lsbr.c1", 3, C_STALL, 2'd0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("lsbr.c2", 3, C_FLUSH, 2'd1);
        idle();
        cyc("lsbr.c3", 3, C_DEF, 2'd0);
        chk("lsbr.flush_count", 32'(fc3), 32'd1);

        // Memory timeout on u1 (MEM_TIMEOUT=4)
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("to.c1", 1, C_HOLD, 2'd0);
        cyc("to.c2", 1, C_HOLD, 2'd2);
        cyc("to.c3", 1, C_HOLD, 2'd2);
        cyc("to.c4", 1, C_HOLD, 2'd2);
        chk("to.err_before", 32'(err1), 32'd0);
        cyc("to.c5", 1, C_DEF, 2'd2);
        chk("to.err_set", 32'(err1), 32'd1);
        chk("to.state_run", 32'(st1), 32'd0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("to.err_sticky", 32'(err1), 32'd1);
        do_reset();
        chk("to.err_cleared", 32'(err1), 32'd0);

        // Reset during the second MEM_WAIT cycle on u3
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("rmw.c1", 3, C_HOLD, 2'd0);
        cyc("rmw.c2", 3, C_HOLD, 2'd2);
        chk("rmw.state_pre", 32'(st3), 32'd2);
        rst = 1'b1;
        #1;
        chk("rmw.state", 32'(st3), 32'd0);
        chk("rmw.stall_count", 32'(sc3), 32'd0);
        chk("rmw.ctrl", 32'(c3), 32'(C_RST));
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("rmw.after", 3, C_DEF, 2'd0);

        // Counter saturation on u1 (CNT_W=4)
        do_reset();
        drive(5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("sat.stall_count", 32'(sc1), 32'd15);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("sat.flush_count", 32'(fc1), 32'd15);
        chk("sat.stall_hold", 32'(sc1), 32'd15);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
